// File: rtl/ci_frame_ctrl.sv
// Purpose: raster-reads one frame from memory, streams it to the CI datapath, then waits for all radii to finish.
// Latency: pixel k appears on grayscale_o/done_o two cycles after its read strobe, three cycles after start_i.
// Backpressure: none; the stream is fixed-rate, and abort_i is the only way to cut a frame short.
module ci_frame_ctrl #(
    parameter int COLS    = 30,
    parameter int ROWS    = 30,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_data_i,
    output logic [7:0]        grayscale_o,
    output logic              done_o,
    input  logic              done_R2_i,
    input  logic              done_R4_i,
    input  logic              done_R6_i,
    input  logic              done_R8_i,
    output logic              busy_o,
    output logic              frame_done_o,
    output logic [3:0]        radius_seen_o,
    output logic              err_timeout_o
);

    localparam int N       = ROWS * COLS;
    localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;
    localparam int DRAIN_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   ADDR_LAST  = CNT_W'(N - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0]   addr_q;
    logic               rd_act_q;
    logic               rd_q;
    logic               done_q;
    logic [7:0]         gray_q;
    logic [DRAIN_W-1:0] drain_cnt_q;
    logic [3:0]         radius_q;
    logic               err_q;

    logic launch;
    logic flag_en;
    logic timeout_hit;
    logic flags_full;
    logic drain_expired;
    logic last_pix;

    assign flags_full    = (radius_q == 4'hF);
    assign drain_expired = (drain_cnt_q == DRAIN_LAST);
    // The pixel stream is contiguous, so a valid pixel with no read behind it is the last one.
    assign last_pix      = done_q && !rd_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (start_i) state_d = S_FETCH;
                S_FETCH:  state_d = S_STREAM;
                S_STREAM: if (last_pix) state_d = S_DRAIN;
                S_DRAIN:  if (flags_full || drain_expired) state_d = S_FINISH;
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (state_q != S_IDLE);
        frame_done_o = (state_q == S_FINISH) && !abort_i;
        launch       = (state_q == S_IDLE) && start_i && !abort_i;
        flag_en      = (state_q == S_STREAM) || (state_q == S_DRAIN);
        timeout_hit  = (state_q == S_DRAIN) && !flags_full && drain_expired && !abort_i;
    end

    // Read issue and the two-stage pixel pipeline; abort flushes reads already in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_act_q <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            done_q   <= 1'b0;
            gray_q   <= 8'h00;
        end else if (abort_i) begin
            rd_act_q <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            done_q   <= 1'b0;
            gray_q   <= 8'h00;
        end else begin
            rd_q   <= rd_act_q;
            done_q <= rd_q;
            gray_q <= rd_q ? mem_data_i : 8'h00;
            if (launch) begin
                rd_act_q <= 1'b1;
                addr_q   <= '0;
            end else if (rd_act_q) begin
                if (addr_q == ADDR_LAST) begin
                    rd_act_q <= 1'b0;
                    addr_q   <= '0;
                end else begin
                    addr_q <= addr_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt_q <= '0;
        end else if (state_q == S_DRAIN) begin
            if (!drain_expired) begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end
        end else begin
            drain_cnt_q <= '0;
        end
    end

    // Completion flags are sticky across frames until the next accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            radius_q <= 4'b0000;
            err_q    <= 1'b0;
        end else if (launch) begin
            radius_q <= 4'b0000;
            err_q    <= 1'b0;
        end else begin
            if (flag_en) begin
                radius_q <= radius_q | {done_R8_i, done_R6_i, done_R4_i, done_R2_i};
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mem_rd_o      = rd_act_q;
    assign mem_addr_o    = ADDR_W'(addr_q);
    assign grayscale_o   = gray_q;
    assign done_o        = done_q;
    assign radius_seen_o = radius_q;
    assign err_timeout_o = err_q;

endmodule

// File: tb/tb_ci_frame_ctrl.sv
// Bench for ci_frame_ctrl: 4x4 frame, drain timeout of 32, memory returns addr+1 plus a per-frame offset.
// Expected outputs come from a cycle-indexed timeline derived from the frame rules, not from the RTL structure.
module tb_ci_frame_ctrl;

    localparam int COLS     = 4;
    localparam int ROWS     = 4;
    localparam int N        = ROWS * COLS;
    localparam int ADDR_W   = 10;
    localparam int TIMEOUT  = 32;
    localparam int PMAX     = 64;
    localparam int NO_ABORT = 1000;
    localparam int OW       = ADDR_W + 17;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              abort_i = 1'b0;
    logic              mem_rd_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_i = 8'h00;
    logic [7:0]        grayscale_o;
    logic              done_o;
    logic              done_R2_i = 1'b0;
    logic              done_R4_i = 1'b0;
    logic              done_R6_i = 1'b0;
    logic              done_R8_i = 1'b0;
    logic              busy_o;
    logic              frame_done_o;
    logic [3:0]        radius_seen_o;
    logic              err_timeout_o;
    logic [OW-1:0]     outs_all;

    int         checks = 0;
    int         errors = 0;
    int         mem_ofs = 0;
    logic [3:0] pulse_tab [0:PMAX-1];
    logic       restart_tab [0:PMAX-1];
    logic [3:0] prev_flags = 4'b0000;
    logic       prev_err = 1'b0;

    ci_frame_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .mem_rd_o(mem_rd_o), .mem_addr_o(mem_addr_o), .mem_data_i(mem_data_i),
        .grayscale_o(grayscale_o), .done_o(done_o),
        .done_R2_i(done_R2_i), .done_R4_i(done_R4_i), .done_R6_i(done_R6_i), .done_R8_i(done_R8_i),
        .busy_o(busy_o), .frame_done_o(frame_done_o), .radius_seen_o(radius_seen_o),
        .err_timeout_o(err_timeout_o)
    );

    always #5 clk = ~clk;

    assign outs_all = {mem_rd_o, mem_addr_o, grayscale_o, done_o, busy_o,
                       frame_done_o, radius_seen_o, err_timeout_o};

    // Frame memory: one-cycle read latency, garbage on the bus when not read.
    always @(posedge clk) begin
        if (mem_rd_o) mem_data_i <= 8'(int'(mem_addr_o) + 1 + mem_ofs);
        else          mem_data_i <= 8'($urandom);
    end

    function automatic void clear_tabs();
        for (int i = 0; i < PMAX; i++) begin
            pulse_tab[i]   = 4'b0000;
            restart_tab[i] = 1'b0;
        end
    endfunction

    // Runs one frame started at relative cycle 0 and checks every output on every cycle.
    task automatic run_frame(input int ofs, input int abort_at);
        int         d0, e_cyc, f_cyc, stop, lim;
        logic       to_hit;
        logic [3:0] acc, exp_flags;
        logic       exp_rd, exp_done, exp_busy, exp_fd, exp_err;
        logic [ADDR_W-1:0] exp_addr;
        logic [7:0] exp_gray;
        mem_ofs = ofs;
        d0 = N + 3;
        acc = 4'b0000;
        for (int r = 2; r < d0; r++) acc = acc | pulse_tab[r];
        e_cyc = -1;
        to_hit = 1'b0;
        for (int d = d0; d < PMAX && e_cyc < 0; d++) begin
            if (acc == 4'hF) e_cyc = d;
            else if (d == d0 + TIMEOUT - 1) begin
                e_cyc = d;
                to_hit = 1'b1;
            end else acc = acc | pulse_tab[d];
        end
        f_cyc = e_cyc + 1;
        stop = (abort_at < f_cyc) ? abort_at : f_cyc;
        exp_flags = prev_flags;
        exp_err = prev_err;
        for (int r = 0; r <= stop + 2; r++) begin
            @(posedge clk); #1;
            start_i = (r == 0) || (r <= stop && restart_tab[r]);
            abort_i = (r == abort_at);
            {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = pulse_tab[r];
            @(negedge clk);
            exp_rd   = (r >= 1) && (r <= N) && (r <= abort_at);
            exp_addr = exp_rd ? ADDR_W'(r - 1) : '0;
            exp_done = (r >= 3) && (r <= N + 2) && (r <= abort_at);
            exp_gray = exp_done ? 8'(r - 2 + ofs) : 8'h00;
            exp_busy = (r >= 1) && (r <= stop);
            exp_fd   = (r == f_cyc) && (abort_at > f_cyc);
            if (r == 0) begin
                exp_flags = prev_flags;
                exp_err = prev_err;
            end else begin
                lim = r - 1;
                if (e_cyc < lim) lim = e_cyc;
                if (abort_at < lim) lim = abort_at;
                exp_flags = 4'b0000;
                for (int j = 2; j <= lim; j++) exp_flags = exp_flags | pulse_tab[j];
                exp_err = to_hit && (abort_at > e_cyc) && (r >= f_cyc);
            end
            checks += 8;
            if (mem_rd_o !== exp_rd) begin
                errors++; $display("FAIL mem_rd r=%0d got %b exp %b", r, mem_rd_o, exp_rd);
            end
            if (mem_addr_o !== exp_addr) begin
                errors++; $display("FAIL mem_addr r=%0d got %0d exp %0d", r, mem_addr_o, exp_addr);
            end
            if (done_o !== exp_done) begin
                errors++; $display("FAIL done r=%0d got %b exp %b", r, done_o, exp_done);
            end
            if (grayscale_o !== exp_gray) begin
                errors++; $display("FAIL grayscale r=%0d got %h exp %h", r, grayscale_o, exp_gray);
            end
            if (busy_o !== exp_busy) begin
                errors++; $display("FAIL busy r=%0d got %b exp %b", r, busy_o, exp_busy);
            end
            if (frame_done_o !== exp_fd) begin
                errors++; $display("FAIL frame_done r=%0d got %b exp %b", r, frame_done_o, exp_fd);
            end
            if (radius_seen_o !== exp_flags) begin
                errors++; $display("FAIL radius_seen r=%0d got %b exp %b", r, radius_seen_o, exp_flags);
            end
            if (err_timeout_o !== exp_err) begin
                errors++; $display("FAIL err_timeout r=%0d got %b exp %b", r, err_timeout_o, exp_err);
            end
        end
        prev_flags = exp_flags;
        prev_err = exp_err;
        start_i = 1'b0;
        abort_i = 1'b0;
        {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (outs_all !== '0) begin
            errors++; $display("FAIL reset_outputs got %h exp 0", outs_all);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(posedge clk); #1;
            {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = 4'hF;
            @(negedge clk);
            checks++;
            if (outs_all !== '0) begin
                errors++; $display("FAIL idle_ignores_radius r=%0d got %h exp 0", r, outs_all);
            end
        end
        {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = 4'b0000;
        prev_flags = 4'b0000;
        prev_err = 1'b0;
    endtask

    task automatic test_nominal();
        clear_tabs();
        pulse_tab[20] = 4'b0001;
        pulse_tab[21] = 4'b0010;
        pulse_tab[22] = 4'b1100;
        run_frame(0, NO_ABORT);
    endtask

    task automatic test_timeout();
        clear_tabs();
        pulse_tab[20] = 4'b0001;
        pulse_tab[25] = 4'b0010;
        run_frame(0, NO_ABORT);
    endtask

    task automatic test_abort();
        clear_tabs();
        pulse_tab[6] = 4'b0101;
        run_frame(0, 10);
        clear_tabs();
        pulse_tab[19] = 4'hF;
        run_frame(0, NO_ABORT);
    endtask

    task automatic test_reset_midframe();
        clear_tabs();
        mem_ofs = 0;
        for (int r = 0; r <= 7; r++) begin
            @(posedge clk); #1;
            start_i = (r == 0) || (r == 5);
            @(negedge clk);
            if (r >= 1) begin
                checks += 2;
                if (busy_o !== 1'b1) begin
                    errors++; $display("FAIL midframe_busy r=%0d got %b exp 1", r, busy_o);
                end
                if (mem_addr_o !== ADDR_W'(r - 1)) begin
                    errors++; $display("FAIL midframe_addr r=%0d got %0d exp %0d", r, mem_addr_o, r - 1);
                end
            end
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (outs_all !== '0) begin
            errors++; $display("FAIL async_reset_outputs got %h exp 0", outs_all);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        for (int r = 0; r < 10; r++) begin
            @(posedge clk); #1;
            {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = 4'($urandom);
            @(negedge clk);
            checks++;
            if (outs_all !== '0) begin
                errors++; $display("FAIL post_reset_quiet r=%0d got %h exp 0", r, outs_all);
            end
        end
        {done_R8_i, done_R6_i, done_R4_i, done_R2_i} = 4'b0000;
        prev_flags = 4'b0000;
        prev_err = 1'b0;
    endtask

    task automatic test_random();
        int dens, drop, ab;
        for (int f = 0; f < 12; f++) begin
            clear_tabs();
            dens = $urandom_range(4, 40);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            for (int r = 0; r < PMAX; r++) begin
                for (int b = 0; b < 4; b++) begin
                    if (b != drop && $urandom_range(0, dens) == 0) pulse_tab[r][b] = 1'b1;
                end
                restart_tab[r] = ($urandom_range(0, 7) == 0);
            end
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 55) : NO_ABORT;
            run_frame($urandom_range(0, 255), ab);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_abort();
        test_reset_midframe();
        test_nominal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
